// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction-fetch queue: PC step, pointer
// width helper and the {pc, inst} queue entry layout.
package ifq_pkg;

  localparam int IFQ_PC_STEP = 4;
  localparam int IFQ_XLEN    = 32;

  // Layout of one buffered instruction; the data queue stores the same
  // {pc, inst} ordering as a flat vector so WIDTH can differ from IFQ_XLEN.
  typedef struct packed {
    logic [IFQ_XLEN-1:0] pc;
    logic [IFQ_XLEN-1:0] inst;
  } ifq_entry_t;

  function automatic int ifq_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count. DEPTH must be a
// power of two so the pointers wrap naturally. The head is read straight
// from storage, so it is a registered value with no path from push_data.
module sync_fifo
  import ifq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head,
  output logic [ifq_ptr_w(DEPTH):0] count
);

  localparam int PW = ifq_ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage, pointers and count; flush empties the FIFO without touching storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches against a
// pipelined imem, tags each with its PC, and buffers returned instructions
// in order for decode. A redirect flushes everything and drops responses
// still in flight before fetching resumes at the new PC.
// Optional build macro IFQ_BYPASS_EN: a response arriving to an empty queue
// is forwarded combinationally to decode (zero-cycle latency).
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [WIDTH-1:0] req_addr,
  input  logic             rsp_valid,
  input  logic [WIDTH-1:0] rsp_inst,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             inst_ready,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc
);

  localparam int PW = ifq_ptr_w(DEPTH);

  logic [WIDTH-1:0]   fetch_pc;
  logic [PW:0]        drop_cnt;
  logic [PW:0]        outstanding;
  logic [PW:0]        data_count;
  logic [PW:0]        drop_sum;
  logic [PW:0]        drop_redirect;
  logic [PW+1:0]      credit_used;
  logic [WIDTH-1:0]   tag_head;
  logic [2*WIDTH-1:0] data_head;
  logic               drop_idle;
  logic               accept;
  logic               rsp_take;
  logic               data_push;
  logic               data_pop;

  // The tag FIFO holds exactly one PC per request still owed by imem, so its
  // occupancy doubles as the outstanding-request counter.
  assign drop_idle   = (drop_cnt == '0);
  assign credit_used = {1'b0, outstanding} + {1'b0, data_count};
  assign req_valid   = rst && !redirect && drop_idle && (credit_used < (PW+2)'(DEPTH));
  assign req_addr    = fetch_pc;
  assign accept      = req_valid && req_ready;
  assign rsp_take    = rsp_valid && drop_idle && !redirect;
  assign data_pop    = (data_count != '0) && inst_ready && !redirect;

  // Every request not yet answered becomes a response to drop; a response
  // landing in the redirect cycle is already accounted for.
  assign drop_sum      = outstanding + drop_cnt;
  assign drop_redirect = drop_sum - (PW+1)'(rsp_valid && (drop_sum != '0));

`ifdef IFQ_BYPASS_EN
  logic bypass_hit;

  assign bypass_hit = (data_count == '0) && rsp_take;
  assign inst_valid = (data_count != '0) || bypass_hit;
  assign inst       = bypass_hit ? rsp_inst : data_head[WIDTH-1:0];
  assign inst_pc    = bypass_hit ? tag_head : data_head[2*WIDTH-1:WIDTH];
  assign data_push  = rsp_take && !(bypass_hit && inst_ready);
`else
  assign inst_valid = (data_count != '0);
  assign inst       = data_head[WIDTH-1:0];
  assign inst_pc    = data_head[2*WIDTH-1:WIDTH];
  assign data_push  = rsp_take;
`endif

  // Fetch PC: reload on redirect (word aligned), otherwise advance per accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00};
    end else if (accept) begin
      fetch_pc <= fetch_pc + WIDTH'(IFQ_PC_STEP);
    end
  end

  // Count of stale responses still to be discarded after a redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (redirect) begin
      drop_cnt <= drop_redirect;
    end else if (rsp_valid && !drop_idle) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rsp_take),
    .head      (tag_head),
    .count     (outstanding)
  );

  sync_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_data_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (data_push),
    .push_data ({tag_head, rsp_inst}),
    .pop       (data_pop),
    .head      (data_head),
    .count     (data_count)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a directed vector table, directed redirect/wrap
// sequences, and randomized traffic against a queue-based reference model
// with an in-order pipelined imem model.
module tb_ifetch_queue;
  import ifq_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h100;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, inst_valid, inst_ready, redirect;
  logic [31:0] req_addr, rsp_inst, inst, inst_pc, redirect_pc;

  always #5 clk = ~clk;

  ifetch_queue #(
    .WIDTH    (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_inst    (rsp_inst),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // imem model: in-order responses, each due a chosen latency after acceptance
  typedef struct {
    int          due;
    logic [31:0] data;
  } imem_t;
  imem_t imem[$];
  int    last_due;
  int    lat_min = 2;
  int    lat_max = 2;

  // reference model state
  logic [31:0] m_pc;
  int          m_drop;
  ifq_entry_t  m_q[$];
  logic [31:0] m_tags[$];

  // samples taken mid-cycle by step()
  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_pc, s_inst, last_rsp;

  typedef struct {
    bit          rr, ir, rv;
    logic [31:0] ri;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_iv;
    logic [31:0] e_pc, e_inst;
    bit          byp_row;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Asserts reset between clock edges, checks reset values, releases at a negedge.
  task automatic do_reset();
    #2;
    rst         = 1'b0;
    req_ready   = 1'b0;
    inst_ready  = 1'b0;
    rsp_valid   = 1'b0;
    rsp_inst    = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    #1;
    check("rst_req_valid", req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    imem.delete();
    last_due = -1;
    m_pc     = RPC;
    m_drop   = 0;
    m_q.delete();
    m_tags.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance model and imem.
  task automatic step(input bit rr_i, input bit ir_i, input bit rd_i, input logic [31:0] rpc_i);
    bit          rv, erv, eiv, byp;
    logic [31:0] rdat, epc, einst;
    ifq_entry_t  e;
    int          due;
    rv   = (imem.size() > 0) && (imem[0].due <= cyc);
    rdat = rv ? imem[0].data : $urandom;
    req_ready   = rr_i;
    inst_ready  = ir_i;
    redirect    = rd_i;
    redirect_pc = rpc_i;
    rsp_valid   = rv;
    rsp_inst    = rdat;
    last_rsp    = rdat;
    #1;
    s_rv   = req_valid;
    s_addr = req_addr;
    s_iv   = inst_valid;
    s_pc   = inst_pc;
    s_inst = inst;

    erv   = !rd_i && (m_tags.size() + m_q.size() < DEPTH) && (m_drop == 0);
    byp   = BYP && (m_q.size() == 0) && (m_drop == 0) && rv && !rd_i && (m_tags.size() > 0);
    eiv   = (m_q.size() != 0) || byp;
    epc   = '0;
    einst = '0;
    if (byp) begin
      epc   = m_tags[0];
      einst = rdat;
    end else if (m_q.size() != 0) begin
      epc   = m_q[0].pc;
      einst = m_q[0].inst;
    end
    check("req_valid", s_rv, erv);
    if (erv) check("req_addr", s_addr, m_pc);
    check("inst_valid", s_iv, eiv);
    if (eiv) begin
      check("inst_pc", s_pc, epc);
      check("inst", s_inst, einst);
    end

    if (rd_i) begin
      m_drop = m_tags.size() + m_drop - (rv ? 1 : 0);
      if (m_drop < 0) m_drop = 0;
      m_tags.delete();
      m_q.delete();
      m_pc = rpc_i & 32'hFFFF_FFFC;
    end else begin
      if ((m_q.size() != 0) && ir_i) void'(m_q.pop_front());
      if (rv) begin
        if (m_drop > 0) begin
          m_drop--;
        end else if (m_tags.size() > 0) begin
          e.pc   = m_tags.pop_front();
          e.inst = rdat;
          if (!(byp && ir_i)) begin
            check("queue_room", m_q.size() < DEPTH, 1);
            m_q.push_back(e);
          end
        end
      end
      if (erv && rr_i) begin
        m_tags.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end

    if (rv) void'(imem.pop_front());
    if (erv && rr_i) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      imem.push_back('{due: due, data: $urandom});
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          eiv;
    bit          rr, ir, rd;
    logic [31:0] rpc, saved;
    rst = 1'b0;

    // Fill with decode stalled, then release; imem driven by hand.
    tbl[0] = '{1, 0, 0, 32'h0,  1, 32'h100, 0, 32'h0,   32'h0,  0};
    tbl[1] = '{1, 0, 0, 32'h0,  1, 32'h104, 0, 32'h0,   32'h0,  0};
    tbl[2] = '{1, 0, 1, 32'hA0, 1, 32'h108, 0, 32'h100, 32'hA0, 1};
    tbl[3] = '{1, 0, 1, 32'hA1, 1, 32'h10C, 1, 32'h100, 32'hA0, 0};
    tbl[4] = '{1, 0, 1, 32'hA2, 0, 32'h0,   1, 32'h100, 32'hA0, 0};
    tbl[5] = '{1, 0, 1, 32'hA3, 0, 32'h0,   1, 32'h100, 32'hA0, 0};
    tbl[6] = '{1, 0, 0, 32'h0,  0, 32'h0,   1, 32'h100, 32'hA0, 0};
    tbl[7] = '{1, 1, 0, 32'h0,  0, 32'h0,   1, 32'h100, 32'hA0, 0};
    tbl[8] = '{1, 1, 0, 32'h0,  1, 32'h110, 1, 32'h104, 32'hA1, 0};
    tbl[9] = '{0, 0, 0, 32'h0,  1, 32'h114, 1, 32'h108, 32'hA2, 0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      req_ready  = tbl[i].rr;
      inst_ready = tbl[i].ir;
      rsp_valid  = tbl[i].rv;
      rsp_inst   = tbl[i].ri;
      redirect   = 1'b0;
      #1;
      check("tbl_req_valid", req_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) check("tbl_req_addr", req_addr, tbl[i].e_addr);
      eiv = tbl[i].byp_row ? BYP : tbl[i].e_iv;
      check("tbl_inst_valid", inst_valid, eiv);
      if (eiv) begin
        check("tbl_inst_pc", inst_pc, tbl[i].e_pc);
        check("tbl_inst", inst, tbl[i].e_inst);
      end
      @(posedge clk);
      @(negedge clk);
    end

    // Latency: first accept, 2-cycle imem, decode always ready.
    lat_min = 2; lat_max = 2;
    do_reset();
    step(1, 1, 0, 0);
    check("lat_addr0", s_addr, 32'h100);
    step(1, 1, 0, 0);
    check("lat_addr1", s_addr, 32'h104);
    step(1, 1, 0, 0);
    saved = last_rsp;
`ifdef IFQ_BYPASS_EN
    check("byp_same_cycle_valid", s_iv, 1);
    check("byp_same_cycle_pc", s_pc, 32'h100);
    check("byp_same_cycle_inst", s_inst, saved);
`else
    check("lat_rsp_cycle_valid", s_iv, 0);
    step(1, 1, 0, 0);
    check("lat_next_valid", s_iv, 1);
    check("lat_next_pc", s_pc, 32'h100);
    check("lat_next_inst", s_inst, saved);
`endif
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0);

    // Redirect with three requests outstanding, none returning that cycle.
    lat_min = 4; lat_max = 4;
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h2003);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      check("drop_req_valid", s_rv, 0);
      check("drop_inst_valid", s_iv, 0);
    end
    step(1, 1, 0, 0);
    check("resume_req_valid", s_rv, 1);
    check("resume_req_addr", s_addr, 32'h2000);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0);

    // Redirect coinciding with a response and decode ready.
    lat_min = 2; lat_max = 2;
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h3000);
    step(1, 1, 0, 0);
    check("coinc_inst_valid", s_iv, 0);
    check("coinc_req_valid", s_rv, 0);
    step(1, 1, 0, 0);
    check("coinc_resume_valid", s_rv, 1);
    check("coinc_resume_addr", s_addr, 32'h3000);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

    // PC wrap at the top of the address space.
    do_reset();
    step(0, 1, 1, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    check("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    check("wrap_valid", s_rv, 1);
    check("wrap_addr_zero", s_addr, 32'h0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

    // Randomized traffic, with a mid-run reset and a stall-heavy phase.
    lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rr  = ($urandom_range(0, 3) != 0);
      ir  = (i >= 1400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(rr, ir, rd, rpc);
      if (i == 900) do_reset();
    end
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
